// File: rtl/prg_ram_writer.sv
// prg_ram_writer
// Captures NES CPU byte writes into the cartridge PRG-RAM window and replays
// them, in CPU order, as single masked 16-bit write requests on the SDRAM
// request port. The CPU strobe is asynchronous to clk and is synchronised here.
// A small FIFO decouples the CPU from SDRAM latency. At most one SDRAM request
// is outstanding at any time.

module prg_ram_writer #(
    parameter int ADDR_BITS  = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           data_in,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [ADDR_BITS-2:0] ram_address,
    output logic [15:0]          ram_data_write,
    output logic [1:0]           ram_wm,
    input  logic                 ram_ack,
    output logic                 busy,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Entry layout: {word address, byte select (addr[0]), data byte}
    localparam int ENT_W = ADDR_BITS + 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // Byte lane mask for a given byte select; a set bit means "do not write".
    function automatic logic [1:0] lane_mask(input logic byte_sel);
        return byte_sel ? 2'b01 : 2'b10;
    endfunction

    // A CPU byte goes to both lanes; the mask picks the lane actually written.
    function automatic logic [15:0] lane_data(input logic [7:0] d);
        return {d, d};
    endfunction

    logic [1:0]           r_we_sync;
    logic                 r_we_prev;
    logic [ENT_W-1:0]     r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]       r_wr_ptr;
    logic [PTR_W:0]       r_rd_ptr;
    logic                 r_overflow;
    state_t               r_state;
    logic                 r_ram_we;
    logic [ADDR_BITS-2:0] r_ram_address;
    logic [15:0]          r_ram_data;
    logic [1:0]           r_ram_wm;

    logic                 w_write_evt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ENT_W-1:0]     w_head;
    state_t               w_next_state;
    logic                 w_ram_req;

    // Two-flop synchroniser on the CPU strobe plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_sync <= 2'b00;
            r_we_prev <= 1'b0;
        end else begin
            r_we_sync <= {r_we_sync[0], we};
            r_we_prev <= r_we_sync[1];
        end
    end

    // One write event per strobe pulse, however long the CPU holds it high.
    assign w_write_evt = r_we_sync[1] & ~r_we_prev;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // A pop in the same cycle frees a slot, so a push onto a full FIFO is still taken.
    assign w_push = w_write_evt & (~w_full | w_pop);
    assign w_drop = w_write_evt & w_full & ~w_pop;

    assign w_head = r_fifo[r_rd_ptr[PTR_W-1:0]];

    // FIFO storage; address and data are stable while the strobe is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= {addr, data_in};
        end
    end

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Sticky record that at least one CPU write was lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Request sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-state strobes; an ack outside WAIT_ACK is ignored.
    always_comb begin
        w_next_state = r_state;
        w_ram_req    = 1'b0;
        w_pop        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_ram_req    = 1'b1;
                w_next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ram_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request fields load from the FIFO head on pop and hold until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= 16'h0000;
            r_ram_wm      <= 2'b11;
        end else if (w_pop) begin
            r_ram_we      <= 1'b1;
            r_ram_address <= w_head[ENT_W-1:9];
            r_ram_data    <= lane_data(w_head[7:0]);
            r_ram_wm      <= lane_mask(w_head[8]);
        end
    end

    assign ram_req        = w_ram_req;
    assign ram_we         = r_ram_we;
    assign ram_address    = r_ram_address;
    assign ram_data_write = r_ram_data;
    assign ram_wm         = r_ram_wm;
    assign busy           = ~w_empty | (r_state != IDLE);
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_prg_ram_writer.sv
// tb_prg_ram_writer
// Drives CPU byte writes into prg_ram_writer, answers SDRAM requests and
// compares every request against an in-order queue of expected writes.

module tb_prg_ram_writer;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [22:0] addr;
    logic [7:0]  data_in;
    logic        ram_req;
    logic        ram_we;
    logic [21:0] ram_address;
    logic [15:0] ram_data_write;
    logic [1:0]  ram_wm;
    logic        ram_ack;
    logic        busy;
    logic        overflow;

    prg_ram_writer #(.ADDR_BITS(23), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data_in(data_in),
        .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_write(ram_data_write), .ram_wm(ram_wm), .ram_ack(ram_ack),
        .busy(busy), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
    } exp_t;

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
        logic [21:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_wm;
    } vec_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          last_req_cyc = 0;
    logic [21:0] last_addr;
    logic [15:0] last_data;
    logic [1:0]  last_wm;
    bit          outstanding = 0;
    bit          waiting = 0;
    bit          ack_hold = 0;
    bit          rand_ack = 0;
    int          ack_timer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance one clock, then observe the request port and run the ack responder.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #2;
        cyc++;
        if (ram_ack) begin
            outstanding = 0;
            waiting     = 0;
            ram_ack     = 1'b0;
        end
        if (!rst_n) begin
            outstanding = 0;
            waiting     = 0;
        end else if (ram_req) begin
            chk("req_overlap", 32'(outstanding), 32'd0);
            chk("req_is_write", 32'(ram_we), 32'd1);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req actual=addr %0h required=no request", ram_address);
            end else begin
                e = exp_q.pop_front();
                if (ram_address !== e.a || ram_data_write !== e.d || ram_wm !== e.m) begin
                    errors++;
                    $display("FAIL req_order actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                             ram_address, ram_data_write, ram_wm, e.a, e.d, e.m);
                end
            end
            outstanding  = 1;
            waiting      = 1;
            ack_timer    = rand_ack ? int'($urandom_range(0, 2)) : 0;
            req_cnt++;
            last_req_cyc = cyc;
            last_addr    = ram_address;
            last_data    = ram_data_write;
            last_wm      = ram_wm;
        end else if (waiting && !ack_hold) begin
            if (ack_timer == 0) ram_ack = 1'b1;
            else ack_timer--;
        end
    endtask

    task automatic cpu_write(input logic [22:0] a, input logic [7:0] d,
                             input int hi, input int lo, input bit expect_push);
        exp_t e;
        if (expect_push) begin
            e.a = a[22:1];
            e.d = {d, d};
            e.m = a[0] ? 2'b01 : 2'b10;
            exp_q.push_back(e);
        end
        addr    = a;
        data_in = d;
        we      = 1'b1;
        repeat (hi) tick();
        we = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_reqs(input int target, input int limit, input string name);
        int n = 0;
        while (req_cnt < target && n < limit) begin
            tick();
            n++;
        end
        chk(name, 32'(req_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_ack();
        ram_ack = 1'b1;
        tick();
    endtask

    vec_t vecs[6];
    int   t0;
    int   base;

    initial begin
        vecs[0] = '{23'h000010, 8'hA5, 22'h000008, 16'hA5A5, 2'b10};
        vecs[1] = '{23'h000011, 8'h3C, 22'h000008, 16'h3C3C, 2'b01};
        vecs[2] = '{23'h7FFFFF, 8'hFF, 22'h3FFFFF, 16'hFFFF, 2'b01};
        vecs[3] = '{23'h000000, 8'h00, 22'h000000, 16'h0000, 2'b10};
        vecs[4] = '{23'h400001, 8'h5A, 22'h200000, 16'h5A5A, 2'b01};
        vecs[5] = '{23'h2AAAAA, 8'hC3, 22'h155555, 16'hC3C3, 2'b10};

        rst_n   = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;
        ram_ack = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_data", 32'(ram_data_write), 32'd0);
        chk("rst_wm", 32'(ram_wm), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single write: request lands on the 4th edge after the strobe rises
        ack_hold = 1;
        base = req_cnt;
        t0 = cyc;
        cpu_write(23'h000010, 8'hA5, 3, 3, 1);
        wait_reqs(base + 1, 20, "single_req");
        chk("single_latency", 32'(last_req_cyc - t0), 32'd4);
        chk("single_addr", 32'(last_addr), 32'h000008);
        chk("single_data", 32'(last_data), 32'hA5A5);
        chk("single_wm", 32'(last_wm), 32'd2);
        repeat (2) tick();
        chk("single_hold_addr", 32'(ram_address), 32'h000008);
        chk("single_busy_wait", 32'(busy), 32'd1);
        pulse_ack();
        chk("single_busy_after_ack", 32'(busy), 32'd0);
        ack_hold = 0;

        // Table of encodings
        for (int i = 0; i < 6; i++) begin
            base = req_cnt;
            cpu_write(vecs[i].addr, vecs[i].data, 2, 3, 1);
            wait_reqs(base + 1, 20, "tbl_req");
            chk("tbl_addr", 32'(last_addr), 32'(vecs[i].exp_addr));
            chk("tbl_data", 32'(last_data), 32'(vecs[i].exp_wdata));
            chk("tbl_wm", 32'(last_wm), 32'(vecs[i].exp_wm));
            wait_idle(20, "tbl_idle");
        end

        // Randomised traffic with random ack latency
        rand_ack = 1;
        base = req_cnt;
        for (int i = 0; i < 40; i++) begin
            cpu_write(23'($urandom), 8'($urandom), int'($urandom_range(2, 4)),
                      int'($urandom_range(3, 6)), 1);
        end
        wait_idle(200, "rnd_idle");
        chk("rnd_count", 32'(req_cnt), 32'(base + 40));
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_ovf", 32'(overflow), 32'd0);
        rand_ack = 0;

        // Burst of 4 with acks held off for 50 clocks
        ack_hold = 1;
        base = req_cnt;
        for (int i = 0; i < 4; i++) begin
            cpu_write(23'h001000 + 23'(i), 8'h10 + 8'(i), 2, 3, 1);
        end
        repeat (50) tick();
        chk("burst_in_flight", 32'(req_cnt), 32'(base + 1));
        chk("burst_ovf", 32'(overflow), 32'd0);
        chk("burst_busy", 32'(busy), 32'd1);
        ack_hold = 0;
        wait_reqs(base + 4, 100, "burst_drain");
        wait_idle(50, "burst_idle");
        chk("burst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Long strobe gives one push; spurious ack in IDLE does nothing
        base = req_cnt;
        cpu_write(23'h002468, 8'h9E, 20, 4, 1);
        wait_idle(50, "long_idle");
        chk("long_one_req", 32'(req_cnt), 32'(base + 1));
        pulse_ack();
        repeat (5) tick();
        chk("spur_req_cnt", 32'(req_cnt), 32'(base + 1));
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_req", 32'(ram_req), 32'd0);

        // Overflow: 1 in flight + 4 queued, 6th write dropped
        ack_hold = 1;
        base = req_cnt;
        for (int i = 0; i < 6; i++) begin
            cpu_write(23'h003000 + 23'(i), 8'hE0 + 8'(i), 2, 3, (i < 5));
        end
        repeat (10) tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_in_flight", 32'(req_cnt), 32'(base + 1));
        ack_hold = 0;
        wait_reqs(base + 5, 200, "ovf_drain");
        wait_idle(50, "ovf_idle");
        repeat (10) tick();
        chk("ovf_exact_five", 32'(req_cnt), 32'(base + 5));
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for an ack with two entries queued
        ack_hold = 1;
        base = req_cnt;
        for (int i = 0; i < 3; i++) begin
            cpu_write(23'h004000 + 23'(2 * i), 8'h70 + 8'(i), 2, 3, 1);
        end
        chk("rstmid_busy", 32'(busy), 32'd1);
        chk("rstmid_in_flight", 32'(req_cnt), 32'(base + 1));
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(ram_req), 32'd0);
        chk("rstmid_we", 32'(ram_we), 32'd0);
        chk("rstmid_addr", 32'(ram_address), 32'd0);
        chk("rstmid_data", 32'(ram_data_write), 32'd0);
        chk("rstmid_wm", 32'(ram_wm), 32'd3);
        chk("rstmid_busy0", 32'(busy), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        ack_hold = 0;
        pulse_ack();
        repeat (10) tick();
        chk("rstmid_no_req", 32'(req_cnt), 32'(base + 1));
        chk("rstmid_idle", 32'(busy), 32'd0);
        cpu_write(23'h000123, 8'h77, 2, 3, 1);
        wait_reqs(base + 2, 20, "rstmid_new_req");
        chk("rstmid_new_addr", 32'(last_addr), 32'h000091);
        chk("rstmid_new_wm", 32'(last_wm), 32'd1);
        chk("rstmid_new_data", 32'(last_data), 32'h7777);
        wait_idle(20, "rstmid_new_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
